// File: rtl/uart_rx_pkg.sv
// Shared receiver definitions: FSM state encoding and legal oversampling ratios.
package uart_rx_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } rx_state_e;

  localparam logic [5:0] PRESC_8  = 6'd8;
  localparam logic [5:0] PRESC_16 = 6'd16;
  localparam logic [5:0] PRESC_32 = 6'd32;

  // Anything but 16 or 32 falls back to the smallest ratio.
  function automatic logic [5:0] legal_prescale(input logic [5:0] p);
    return (p == PRESC_16 || p == PRESC_32) ? p : PRESC_8;
  endfunction

endpackage

// File: rtl/uart_rx_ctrl_data_sampling.sv
// Three-point majority voter: samples RX_IN around mid-bit and registers the vote.
module data_sampling
  import uart_rx_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       RX_IN,
  input  logic [5:0] half_i,
  input  logic [5:0] edge_cnt_i,
  output logic       sampled_bit_o
);

  logic [1:0] smp_q;
  logic       bit_q;

  // The third sample is taken live so the vote lands on the following cycle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      smp_q <= 2'b11;
      bit_q <= 1'b1;
    end else begin
      if (edge_cnt_i == half_i - 6'd1) smp_q[0] <= RX_IN;
      if (edge_cnt_i == half_i)        smp_q[1] <= RX_IN;
      if (edge_cnt_i == half_i + 6'd1)
        bit_q <= (smp_q[0] & smp_q[1]) | (smp_q[0] & RX_IN) | (smp_q[1] & RX_IN);
    end
  end

  assign sampled_bit_o = bit_q;

endmodule

// File: rtl/uart_rx_ctrl.sv
// Oversampled UART receive controller: bit/edge counters, frame FSM and strobes.
// Define UART_RX_STRT_GLITCH_EN to reject start bits that vote high at mid-bit.
module uart_rx_ctrl
  import uart_rx_pkg::*;
#(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  RX_IN,
  input  logic [5:0]            Prescale,
  input  logic                  PAR_EN,
  input  logic                  par_err,
  output logic                  sampled_bit,
  output logic                  par_chk_en,
  output logic [DATA_WIDTH-1:0] P_DATA,
  output logic                  data_valid,
  output logic                  stp_err
);

  localparam int            BW     = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [BW-1:0] B_LAST = BW'(DATA_WIDTH - 1);

  rx_state_e             state_q, state_d;
  logic [5:0]            e_q, e_d, p_q, p_d;
  logic [BW-1:0]         b_q, b_d;
  logic                  par_en_q, par_en_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic                  stp_q, stp_d, chk_q, chk_d, dv_q, dv_d;
  logic [5:0]            half;
  logic                  e_last, e_prelast, e_vote, e_use;

  assign half      = {1'b0, p_q[5:1]};
  assign e_last    = (e_q == p_q - 6'd1);
  assign e_prelast = (e_q == p_q - 6'd2);
  assign e_vote    = (e_q == half + 6'd1);
  assign e_use     = (e_q == half + 6'd2);

  data_sampling u_sampler (
    .clk           (clk),
    .reset         (reset),
    .RX_IN         (RX_IN),
    .half_i        (half),
    .edge_cnt_i    (e_q),
    .sampled_bit_o (sampled_bit)
  );

  always_comb begin
    state_d  = state_q;
    e_d      = e_q + 6'd1;
    b_d      = b_q;
    p_d      = p_q;
    par_en_d = par_en_q;
    data_d   = data_q;
    stp_d    = stp_q;
    chk_d    = 1'b0;
    dv_d     = 1'b0;
    case (state_q)
      // The cycle that first sees the line low is E=0 of the start bit.
      ST_IDLE: begin
        e_d = 6'd0;
        if (!RX_IN) begin
          state_d  = ST_START;
          e_d      = 6'd1;
          p_d      = legal_prescale(Prescale);
          par_en_d = PAR_EN;
          stp_d    = 1'b0;
        end
      end
      ST_START: begin
        if (e_last) begin
          state_d = ST_DATA;
          e_d     = 6'd0;
          b_d     = '0;
        end
`ifdef UART_RX_STRT_GLITCH_EN
        if (e_use && sampled_bit) begin
          state_d = ST_IDLE;
          e_d     = 6'd0;
        end
`endif
      end
      ST_DATA: begin
        if (e_use) data_d = {sampled_bit, data_q[DATA_WIDTH-1:1]};
        if (e_last) begin
          e_d = 6'd0;
          if (b_q == B_LAST) state_d = par_en_q ? ST_PARITY : ST_STOP;
          else               b_d = b_q + BW'(1);
        end
      end
      ST_PARITY: begin
        chk_d = e_vote;
        if (e_last) begin
          state_d = ST_STOP;
          e_d     = 6'd0;
        end
      end
      ST_STOP: begin
        if (e_use) stp_d = ~sampled_bit;
        // Decided one cycle early so the strobe sits on the last edge of the frame.
        if (e_prelast) dv_d = ~stp_d & (~par_en_q | ~par_err);
        if (e_last) begin
          e_d = 6'd0;
          if (!RX_IN) begin
            state_d  = ST_START;
            p_d      = legal_prescale(Prescale);
            par_en_d = PAR_EN;
            stp_d    = 1'b0;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
        e_d     = 6'd0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= ST_IDLE;
      e_q      <= 6'd0;
      b_q      <= '0;
      p_q      <= PRESC_8;
      par_en_q <= 1'b0;
      data_q   <= '0;
      stp_q    <= 1'b0;
      chk_q    <= 1'b0;
      dv_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      e_q      <= e_d;
      b_q      <= b_d;
      p_q      <= p_d;
      par_en_q <= par_en_d;
      data_q   <= data_d;
      stp_q    <= stp_d;
      chk_q    <= chk_d;
      dv_q     <= dv_d;
    end
  end

  assign P_DATA     = data_q;
  assign stp_err    = stp_q;
  assign par_chk_en = chk_q;
  assign data_valid = dv_q;

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Self-checking bench for uart_rx_ctrl: frame-level reference model plus strobe monitor.
module tb_uart_rx_ctrl;
  localparam int DW = 8;

  logic          clk = 1'b0, reset = 1'b1, RX_IN = 1'b1, PAR_EN = 1'b0, par_err = 1'b0;
  logic [5:0]    Prescale = 6'd8;
  logic          sampled_bit, par_chk_en, data_valid, stp_err;
  logic [DW-1:0] P_DATA;

  int checks = 0, errors = 0, cyc = 0;
  int            dv_cyc[$];
  logic [DW-1:0] dv_dat[$];
  int            chk_cyc[$];
  bit            par_bad_now = 1'b0;

  uart_rx_ctrl #(.DATA_WIDTH(DW)) dut (
    .clk(clk), .reset(reset), .RX_IN(RX_IN), .Prescale(Prescale), .PAR_EN(PAR_EN),
    .par_err(par_err), .sampled_bit(sampled_bit), .par_chk_en(par_chk_en),
    .P_DATA(P_DATA), .data_valid(data_valid), .stp_err(stp_err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Strobe log plus a stand-in downstream parity checker answering each par_chk_en.
  always @(negedge clk) begin
    if (reset) begin
      if (data_valid) begin dv_cyc.push_back(cyc); dv_dat.push_back(P_DATA); end
      if (par_chk_en) begin chk_cyc.push_back(cyc); par_err = par_bad_now; end
    end
  end

  function automatic int eff_p(input logic [5:0] pr);
    return (pr == 6'd16 || pr == 6'd32) ? int'(pr) : 8;
  endfunction
  function automatic int dv_off(input int p, input bit pen);
    return p * (DW + 2 + (pen ? 1 : 0)) - 1;
  endfunction
  function automatic int chk_off(input int p);
    return (DW + 1) * p + p / 2 + 2;
  endfunction

  task automatic tick();
    @(posedge clk); #1;
  endtask
  task automatic idle(input int n);
    RX_IN = 1'b1;
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Called just after a rising edge; c0 is the edge count when the line drops.
  task automatic send_frame(input logic [DW-1:0] d, input logic [5:0] pr, input bit pen,
                            input bit pbad, input bit stop_low, input bit scramble,
                            output int c0);
    int p, nb;
    logic [DW+2:0] bits;
    p = eff_p(pr);
    nb = DW + 2 + (pen ? 1 : 0);
    bits = '1;
    bits[0] = 1'b0;
    for (int i = 0; i < DW; i++) bits[i+1] = d[i];
    if (pen) bits[DW+1] = (^d) ^ pbad;
    Prescale = pr; PAR_EN = pen; par_bad_now = pbad; c0 = cyc;
    for (int i = 0; i < nb; i++) begin
      for (int k = 0; k < p; k++) begin
        RX_IN = (i == nb - 1 && stop_low && k < p - 2) ? 1'b0 : bits[i];
        tick();
        if (scramble && i == 0 && k == 0) begin
          Prescale = 6'($urandom_range(0, 63));
          PAR_EN = ~pen;
        end
      end
    end
    RX_IN = 1'b1; Prescale = pr; PAR_EN = pen;
  endtask

  task automatic test_reset();
    checks++; if (sampled_bit !== 1'b1) begin errors++; $display("FAIL rst_sampled_bit got %b exp 1", sampled_bit); end
    checks++; if (par_chk_en !== 1'b0) begin errors++; $display("FAIL rst_par_chk_en got %b exp 0", par_chk_en); end
    checks++; if (P_DATA !== '0) begin errors++; $display("FAIL rst_P_DATA got %h exp 00", P_DATA); end
    checks++; if (data_valid !== 1'b0) begin errors++; $display("FAIL rst_data_valid got %b exp 0", data_valid); end
    checks++; if (stp_err !== 1'b0) begin errors++; $display("FAIL rst_stp_err got %b exp 0", stp_err); end
  endtask

  task automatic test_basic();
    int n0, k0, c0;
    n0 = dv_cyc.size(); k0 = chk_cyc.size();
    send_frame(8'hA5, 6'd8, 1'b0, 1'b0, 1'b0, 1'b0, c0);
    idle(4);
    checks++; if (dv_cyc.size() - n0 !== 1) begin errors++; $display("FAIL basic_dv_count got %0d exp 1", dv_cyc.size() - n0); end
    if (dv_cyc.size() > n0) begin
      checks++; if (dv_cyc[n0] - c0 !== 79) begin errors++; $display("FAIL basic_dv_cycle got %0d exp 79", dv_cyc[n0] - c0); end
      checks++; if (dv_dat[n0] !== 8'hA5) begin errors++; $display("FAIL basic_dv_data got %h exp a5", dv_dat[n0]); end
    end
    checks++; if (P_DATA !== 8'hA5) begin errors++; $display("FAIL basic_P_DATA got %h exp a5", P_DATA); end
    checks++; if (stp_err !== 1'b0) begin errors++; $display("FAIL basic_stp_err got %b exp 0", stp_err); end
    checks++; if (chk_cyc.size() !== k0) begin errors++; $display("FAIL basic_no_parchk got %0d exp 0", chk_cyc.size() - k0); end
  endtask

  task automatic test_parity_err();
    int n0, k0, c0;
    n0 = dv_cyc.size(); k0 = chk_cyc.size();
    send_frame(8'h3C, 6'd16, 1'b1, 1'b1, 1'b0, 1'b0, c0);
    idle(4);
    checks++; if (chk_cyc.size() - k0 !== 1) begin errors++; $display("FAIL par_chk_count got %0d exp 1", chk_cyc.size() - k0); end
    if (chk_cyc.size() > k0) begin
      checks++; if (chk_cyc[k0] - c0 !== chk_off(16)) begin errors++; $display("FAIL par_chk_cycle got %0d exp %0d", chk_cyc[k0] - c0, chk_off(16)); end
    end
    checks++; if (dv_cyc.size() !== n0) begin errors++; $display("FAIL par_err_dv got %0d exp 0", dv_cyc.size() - n0); end
    checks++; if (P_DATA !== 8'h3C) begin errors++; $display("FAIL par_P_DATA got %h exp 3c", P_DATA); end
  endtask

  task automatic test_stop_err();
    int n0, c0, c1;
    logic [DW-1:0] d2;
    n0 = dv_cyc.size();
    send_frame(8'($urandom), 6'd32, 1'b0, 1'b0, 1'b1, 1'b0, c0);
    idle(20);
    checks++; if (stp_err !== 1'b1) begin errors++; $display("FAIL stop_err_set got %b exp 1", stp_err); end
    checks++; if (dv_cyc.size() !== n0) begin errors++; $display("FAIL stop_err_dv got %0d exp 0", dv_cyc.size() - n0); end
    d2 = 8'($urandom);
    fork
      send_frame(d2, 6'd32, 1'b0, 1'b0, 1'b0, 1'b0, c1);
      begin
        tick(); tick();
        checks++; if (stp_err !== 1'b0) begin errors++; $display("FAIL stop_err_clear got %b exp 0", stp_err); end
      end
    join
    idle(4);
    checks++; if (dv_cyc.size() - n0 !== 1) begin errors++; $display("FAIL stop_next_dv got %0d exp 1", dv_cyc.size() - n0); end
    if (dv_cyc.size() > n0) begin
      checks++; if (dv_dat[n0] !== d2) begin errors++; $display("FAIL stop_next_data got %h exp %h", dv_dat[n0], d2); end
    end
  endtask

  task automatic test_back_to_back();
    int n0, c0, c1;
    n0 = dv_cyc.size();
    send_frame(8'h01, 6'd8, 1'b0, 1'b0, 1'b0, 1'b0, c0);
    send_frame(8'hFF, 6'd8, 1'b0, 1'b0, 1'b0, 1'b0, c1);
    idle(4);
    checks++; if (dv_cyc.size() - n0 !== 2) begin errors++; $display("FAIL b2b_dv_count got %0d exp 2", dv_cyc.size() - n0); end
    if (dv_cyc.size() >= n0 + 2) begin
      checks++; if (dv_cyc[n0+1] - dv_cyc[n0] !== 80) begin errors++; $display("FAIL b2b_spacing got %0d exp 80", dv_cyc[n0+1] - dv_cyc[n0]); end
      checks++; if (dv_dat[n0] !== 8'h01) begin errors++; $display("FAIL b2b_data0 got %h exp 01", dv_dat[n0]); end
      checks++; if (dv_dat[n0+1] !== 8'hFF) begin errors++; $display("FAIL b2b_data1 got %h exp ff", dv_dat[n0+1]); end
    end
  endtask

  task automatic test_glitch();
    int n0, k0, c0, exp_n;
    n0 = dv_cyc.size(); k0 = chk_cyc.size();
    Prescale = 6'd8; PAR_EN = 1'b0; c0 = cyc;
    RX_IN = 1'b0; tick(); tick();
    idle(100);
`ifdef UART_RX_STRT_GLITCH_EN
    exp_n = 0;
`else
    exp_n = 1;
`endif
    checks++; if (dv_cyc.size() - n0 !== exp_n) begin errors++; $display("FAIL glitch_dv_count got %0d exp %0d", dv_cyc.size() - n0, exp_n); end
    if (exp_n == 1 && dv_cyc.size() > n0) begin
      checks++; if (dv_cyc[n0] - c0 !== 79) begin errors++; $display("FAIL glitch_dv_cycle got %0d exp 79", dv_cyc[n0] - c0); end
      checks++; if (dv_dat[n0] !== 8'hFF) begin errors++; $display("FAIL glitch_data got %h exp ff", dv_dat[n0]); end
    end
    checks++; if (chk_cyc.size() !== k0) begin errors++; $display("FAIL glitch_parchk got %0d exp 0", chk_cyc.size() - k0); end
    checks++; if (stp_err !== 1'b0) begin errors++; $display("FAIL glitch_stp_err got %b exp 0", stp_err); end
  endtask

  task automatic test_reset_mid();
    int n0, c0;
    logic [DW-1:0] d;
    Prescale = 6'd8; PAR_EN = 1'b0;
    RX_IN = 1'b0;
    repeat (8) tick();
    repeat (20) begin RX_IN = 1'($urandom); tick(); end
    n0 = dv_cyc.size();
    #2 reset = 1'b0;
    #1;
    test_reset();
    @(posedge clk); #1;
    reset = 1'b1;
    idle(3);
    checks++; if (dv_cyc.size() !== n0) begin errors++; $display("FAIL rstmid_dv got %0d exp 0", dv_cyc.size() - n0); end
    d = 8'($urandom);
    send_frame(d, 6'd8, 1'b0, 1'b0, 1'b0, 1'b0, c0);
    idle(4);
    checks++; if (dv_cyc.size() - n0 !== 1) begin errors++; $display("FAIL rstmid_next_count got %0d exp 1", dv_cyc.size() - n0); end
    if (dv_cyc.size() > n0) begin
      checks++; if (dv_cyc[n0] - c0 !== 79) begin errors++; $display("FAIL rstmid_next_cycle got %0d exp 79", dv_cyc[n0] - c0); end
      checks++; if (dv_dat[n0] !== d) begin errors++; $display("FAIL rstmid_next_data got %h exp %h", dv_dat[n0], d); end
    end
  endtask

  task automatic test_random();
    logic [5:0] plist [7] = '{6'd8, 6'd16, 6'd32, 6'd12, 6'd0, 6'd63, 6'd24};
    for (int t = 0; t < 10; t++) begin
      int n0, k0, c0, p, exp_dv;
      logic [DW-1:0] d;
      logic [5:0] pr;
      bit pen, pbad, scr;
      d = 8'($urandom); pr = plist[$urandom_range(0, 6)];
      pen = 1'($urandom); pbad = pen & 1'($urandom); scr = 1'($urandom);
      p = eff_p(pr);
      exp_dv = pbad ? 0 : 1;
      n0 = dv_cyc.size(); k0 = chk_cyc.size();
      send_frame(d, pr, pen, pbad, 1'b0, scr, c0);
      idle($urandom_range(1, 5));
      checks++; if (dv_cyc.size() - n0 !== exp_dv) begin errors++; $display("FAIL rnd%0d_dv_count got %0d exp %0d", t, dv_cyc.size() - n0, exp_dv); end
      if (exp_dv == 1 && dv_cyc.size() > n0) begin
        checks++; if (dv_cyc[n0] - c0 !== dv_off(p, pen)) begin errors++; $display("FAIL rnd%0d_dv_cycle got %0d exp %0d", t, dv_cyc[n0] - c0, dv_off(p, pen)); end
        checks++; if (dv_dat[n0] !== d) begin errors++; $display("FAIL rnd%0d_dv_data got %h exp %h", t, dv_dat[n0], d); end
      end
      checks++; if (chk_cyc.size() - k0 !== int'(pen)) begin errors++; $display("FAIL rnd%0d_parchk_count got %0d exp %0d", t, chk_cyc.size() - k0, pen); end
      if (pen && chk_cyc.size() > k0) begin
        checks++; if (chk_cyc[k0] - c0 !== chk_off(p)) begin errors++; $display("FAIL rnd%0d_parchk_cycle got %0d exp %0d", t, chk_cyc[k0] - c0, chk_off(p)); end
      end
      checks++; if (P_DATA !== d) begin errors++; $display("FAIL rnd%0d_P_DATA got %h exp %h", t, P_DATA, d); end
      checks++; if (stp_err !== 1'b0) begin errors++; $display("FAIL rnd%0d_stp_err got %b exp 0", t, stp_err); end
    end
  endtask

  initial begin
    #3 reset = 1'b0;
    #4;
    test_reset();
    @(posedge clk); #1;
    reset = 1'b1;
    idle(3);
    test_basic();
    test_parity_err();
    test_stop_err();
    test_back_to_back();
    test_glitch();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_rx_ctrl.md
UART_RX_CTRL -- requirements
Module: uart_rx_ctrl

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8, number of data bits per frame.
REQ-002 SHALL have port clk  input  1  oversampling clock; all state changes on rising edge.
REQ-003 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port RX_IN  input  1  serial line; idle high; LSB first.
REQ-005 SHALL have port Prescale  input  6  oversampling ratio P; legal values 8, 16, 32.
REQ-006 SHALL have port PAR_EN  input  1  1 = frame carries a parity bit.
REQ-007 SHALL have port par_err  input  1  registered result from the downstream parity checker.
REQ-008 SHALL have port sampled_bit  output  1  majority-voted bit value.
REQ-009 SHALL have port par_chk_en  output  1  one-cycle strobe to the parity checker.
REQ-010 SHALL have port P_DATA  output  DATA_WIDTH  deserialized data.
REQ-011 SHALL have port data_valid  output  1  one-cycle frame-good strobe.
REQ-012 SHALL have port stp_err  output  1  stop-bit framing error flag.

Function
REQ-013 SHALL run FSM states IDLE, START, DATA, PARITY, STOP.
REQ-014 SHALL keep edge counter E (0..P-1) per bit period and bit counter B (0..DATA_WIDTH-1) in DATA.
REQ-015 SHALL leave IDLE for START on the first cycle with RX_IN=0; that cycle is E=0 of the start bit.
REQ-016 SHALL sample RX_IN at E=P/2-1, P/2, P/2+1 and drive sampled_bit as their 2-of-3 majority from E=P/2+2 until the next bit's update.
REQ-017 SHALL end each bit at E=P-1; next cycle is E=0 of the following bit.
REQ-018 SHALL go START->DATA, DATA(B=DATA_WIDTH-1)->PARITY if PAR_EN=1 else STOP, PARITY->STOP, each at E=P-1.
REQ-019 SHALL shift sampled_bit into P_DATA (LSB first) at E=P/2+2 of each DATA bit; P_DATA holds between frames.
REQ-020 SHALL pulse par_chk_en high for exactly the one cycle E=P/2+2 in PARITY; never when PAR_EN=0.
REQ-021 SHALL set stp_err at E=P/2+2 of STOP to ~sampled_bit and hold it until the next START entry clears it.
REQ-022 SHALL pulse data_valid at E=P-1 of STOP iff stp_err=0 and (PAR_EN=0 or par_err=0).
REQ-023 SHALL, at E=P-1 of STOP, go to START (E=0) if RX_IN=0 (back-to-back frame), else IDLE.
REQ-024 SHALL treat any Prescale other than 8/16/32 as 8.
REQ-025 SHALL ignore Prescale/PAR_EN changes except in IDLE; values captured on START entry.

Reset
REQ-026 SHALL, on reset low, asynchronously enter IDLE with E=0, B=0, P_DATA=0, sampled_bit=1, par_chk_en=0, data_valid=0, stp_err=0.
REQ-027 SHALL abort any in-flight frame on reset with no data_valid; first frame after release needs a fresh falling edge.

Configuration
REQ-028 SHALL support macro UART_RX_STRT_GLITCH_EN: when defined, sampled_bit=1 at E=P/2+2 of START returns FSM to IDLE with no strobes; when undefined, the start bit is not checked and START always proceeds to DATA.

Structure
REQ-029 SHALL take FSM state encoding and legal-prescale constants from shared package uart_rx_pkg.
REQ-030 SHALL place the three-sample majority voter in sub-module data_sampling; counters and FSM stay in uart_rx_ctrl.

Verification
REQ-031 SHALL check: P=8, PAR_EN=0, frame 0xA5, stop=1 -> P_DATA=0xA5, data_valid one cycle at 80th clock after falling edge, stp_err=0.
REQ-032 SHALL check: P=16, PAR_EN=1, 0x3C, par_err driven 1 after par_chk_en -> par_chk_en single pulse, no data_valid.
REQ-033 SHALL check: P=32, stop bit 0 -> stp_err=1, no data_valid; stp_err clears on next START.
REQ-034 SHALL check: two back-to-back frames 0x01,0xFF at P=8 -> two data_valid pulses exactly 80 clocks apart.
REQ-035 SHALL check: with UART_RX_STRT_GLITCH_EN, 2-clock low glitch on RX_IN -> FSM back in IDLE, no strobes; without macro, frame is received.
REQ-036 SHALL check: reset asserted mid-DATA -> all outputs at reset values immediately, next valid frame received correctly.
